// File: rtl/button_conditioner.sv
// button_conditioner: cleans one raw push-button for the alarm-clock core.
// Path: 2-FF synchroniser -> polarity normalisation -> ms-based debounce FSM
// (IDLE, ARM, HOLD, REPEAT, REL_ARM) -> registered level and one-clk strobes.
// The 1 ms timebase comes from the core (ms_tick); there is no local divider.
// Optional feature: define BUTTON_CONDITIONER_LONG_PRESS_EN to add the
// long_press output, a 12-bit hold counter and the LONG_PRESS_MS threshold.
module button_conditioner #(
    parameter int ACTIVE_LOW       = 1,
    parameter int DEBOUNCE_MS      = 20,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_PERIOD_MS = 100,
    parameter int LONG_PRESS_MS    = 2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ms_tick,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    // Level the raw pin shows when the button is not pressed.
    localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Tick counts are compared against "N-1" so that the N-th tick decides.
    localparam logic [9:0] DEB_LAST = 10'(DEBOUNCE_MS - 1);
    localparam logic [9:0] DLY_LAST = 10'(REPEAT_DELAY_MS - 1);
    localparam logic [9:0] PER_LAST = 10'(REPEAT_PERIOD_MS - 1);
    localparam logic [9:0] CNT_MAX  = 10'h3FF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_HOLD,
        S_REPEAT,
        S_REL_ARM
    } state_t;

    // Synchroniser and normalised pressed level.
    logic r_sync1;
    logic r_sync2;
    logic w_p;

    // FSM state, ms counter and registered outputs.
    state_t     r_state;
    state_t     w_state_next;
    logic [9:0] r_cnt;
    logic [9:0] w_cnt_next;
    logic [9:0] w_cnt_inc;
    logic       r_from_rep;
    logic       w_from_rep_next;
    logic       r_level;
    logic       w_level_next;
    logic       r_press;
    logic       w_press_next;
    logic       r_release;
    logic       w_release_next;

    // Two-flop synchroniser; reset parks it at the released level so a held
    // button is seen as a fresh press after reset and gets re-debounced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= IDLE_LEVEL;
            r_sync2 <= IDLE_LEVEL;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_p = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    // The counter sticks at its maximum instead of wrapping, so a long idle
    // hold can never alias back into a fresh threshold match.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 10'd1;

    // State register plus all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_from_rep <= 1'b0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_from_rep <= w_from_rep_next;
            r_level    <= w_level_next;
            r_press    <= w_press_next;
            r_release  <= w_release_next;
        end
    end

    // Next-state, counter and output decode. A change of w_p is always tested
    // before ms_tick, so a level change in a tick cycle wins and the tick is
    // dropped. Every transition clears the counter.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_from_rep_next = r_from_rep;
        w_level_next    = r_level;
        w_press_next    = 1'b0;
        w_release_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_level_next = 1'b0;
                w_cnt_next   = '0;
                if (w_p) begin
                    w_state_next = S_ARM;
                end
            end

            S_ARM: begin
                w_level_next = 1'b0;
                if (!w_p) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (ms_tick) begin
                    if (r_cnt >= DEB_LAST) begin
                        w_state_next = S_HOLD;
                        w_cnt_next   = '0;
                        w_level_next = 1'b1;
                        w_press_next = 1'b1;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end

            S_HOLD: begin
                w_level_next = 1'b1;
                if (!w_p) begin
                    w_state_next    = S_REL_ARM;
                    w_cnt_next      = '0;
                    w_from_rep_next = 1'b0;
                end else if (ms_tick) begin
                    // ">=" lets repeat start promptly if repeat_en is raised
                    // after the counter has already passed the delay.
                    if (repeat_en && (r_cnt >= DLY_LAST)) begin
                        w_state_next = S_REPEAT;
                        w_cnt_next   = '0;
                        w_press_next = 1'b1;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end

            S_REPEAT: begin
                w_level_next = 1'b1;
                if (!w_p) begin
                    w_state_next    = S_REL_ARM;
                    w_cnt_next      = '0;
                    w_from_rep_next = 1'b1;
                end else if (!repeat_en) begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = '0;
                end else if (ms_tick) begin
                    if (r_cnt >= PER_LAST) begin
                        w_cnt_next   = '0;
                        w_press_next = 1'b1;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end

            S_REL_ARM: begin
                w_level_next = 1'b1;
                if (w_p) begin
                    // Bounce during release: resume where we were. If repeat
                    // was switched off meanwhile, land straight in HOLD.
                    w_state_next = (r_from_rep && repeat_en) ? S_REPEAT : S_HOLD;
                    w_cnt_next   = '0;
                end else if (ms_tick) begin
                    if (r_cnt >= DEB_LAST) begin
                        w_state_next   = S_IDLE;
                        w_cnt_next     = '0;
                        w_level_next   = 1'b0;
                        w_release_next = 1'b1;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_level_next = 1'b0;
            end
        endcase
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam logic [11:0] LONG_LAST = 12'(LONG_PRESS_MS - 1);
    localparam logic [11:0] HOLD_MAX  = 12'hFFF;

    logic [11:0] r_hold_cnt;
    logic        r_hold_active;
    logic        r_long;

    // Hold timer: armed on ARM->HOLD, runs through HOLD/REPEAT/REL_ARM
    // bounces, cleared only when the FSM heads to IDLE. It saturates above
    // the largest legal threshold, so the strobe fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt    <= '0;
            r_hold_active <= 1'b0;
            r_long        <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_state_next == S_IDLE) begin
                r_hold_cnt    <= '0;
                r_hold_active <= 1'b0;
            end else begin
                if ((r_state == S_ARM) && (w_state_next == S_HOLD)) begin
                    r_hold_active <= 1'b1;
                end
                if (r_hold_active && ms_tick) begin
                    if (r_hold_cnt != HOLD_MAX) begin
                        r_hold_cnt <= r_hold_cnt + 12'd1;
                    end
                    if (r_hold_cnt == LONG_LAST) begin
                        r_long <= 1'b1;
                    end
                end
            end
        end
    end

    assign long_press = r_long;
`else
    // Threshold has no consumer without the long-press feature.
    logic [11:0] w_unused_long_ms;
    assign w_unused_long_ms = 12'(LONG_PRESS_MS);
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner. ms_tick is mostly held high so
// that every clk is one ms. A monitor logs every pulse and btn_level edge with
// its cycle number; each test pushes the events it expects and then compares
// the two logs in order.
`timescale 1ns/1ps
module tb_button_conditioner;

    localparam int DEB  = 20;
    localparam int DLY  = 500;
    localparam int PER  = 100;
    localparam int LONG = 2000;
    // Raw edge -> pulse: 2 sync clks, 1 clk to leave IDLE/HOLD, DEB ticks.
    localparam int LAT  = 3 + DEB;

    localparam logic [3:0]  K_PRESS   = 4'd1;
    localparam logic [3:0]  K_RELEASE = 4'd2;
    localparam logic [3:0]  K_LONG    = 4'd3;
    localparam logic [3:0]  K_UP      = 4'd4;
    localparam logic [3:0]  K_DN      = 4'd5;
    localparam logic [31:0] NONE      = 32'hFFFF_FFFF;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic ms_tick   = 1'b1;
    logic btn_raw   = 1'b0;
    logic repeat_en = 1'b0;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    logic long_press;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int obs_rd  = 0;
    logic lvl_prev = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    button_conditioner #(
        .ACTIVE_LOW      (1),
        .DEBOUNCE_MS     (DEB),
        .REPEAT_DELAY_MS (DLY),
        .REPEAT_PERIOD_MS(PER),
        .LONG_PRESS_MS   (LONG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ms_tick      (ms_tick),
        .btn_raw      (btn_raw),
        .repeat_en    (repeat_en),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
        ,
        .long_press   (long_press)
`endif
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] ev(input logic [3:0] k, input int c);
        logic [31:0] cv;
        cv = c;
        return {k, cv[27:0]};
    endfunction

    function automatic string kname(input logic [3:0] k);
        case (k)
            K_PRESS:   return "press";
            K_RELEASE: return "release";
            K_LONG:    return "long";
            K_UP:      return "level_up";
            K_DN:      return "level_down";
            default:   return "none";
        endcase
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: cycle counter and event log, sampled 1 ns after each edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (press_pulse)   obs_q.push_back(ev(K_PRESS, cyc));
            if (release_pulse) obs_q.push_back(ev(K_RELEASE, cyc));
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
            if (long_press)    obs_q.push_back(ev(K_LONG, cyc));
`endif
            if (btn_level && !lvl_prev) obs_q.push_back(ev(K_UP, cyc));
            if (!btn_level && lvl_prev) obs_q.push_back(ev(K_DN, cyc));
            lvl_prev = btn_level;
        end
    end

    // Hold the button through reset; release must not pulse, re-debounce must.
    task automatic test_reset();
        int r;
        logic [31:0] e, o;
        rst_n = 1'b0; btn_raw = 1'b0; ms_tick = 1'b1; repeat_en = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 000", {btn_level, press_pulse, release_pulse});
        end
        r = cyc; rst_n = 1'b1;
        wait_until(r + LAT - 1);
        n_tests++;
        if (btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_redebounce_level: got %b required 0", btn_level);
        end
        exp_q.push_back(ev(K_PRESS, r + LAT));
        exp_q.push_back(ev(K_UP, r + LAT));
        wait_until(r + 50); btn_raw = 1'b1;
        exp_q.push_back(ev(K_RELEASE, r + 50 + LAT));
        exp_q.push_back(ev(K_DN, r + 50 + LAT));
        wait_until(r + 100);
        while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
            e = NONE; o = NONE;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_event: got %s@%0d required %s@%0d", kname(o[31:28]), o[27:0], kname(e[31:28]), e[27:0]);
            end
        end
    endtask

    // The counter must advance only on ms_tick, not on every clk.
    task automatic test_tick_gating();
        int n, m;
        logic [31:0] e, o;
        ms_tick = 1'b0;
        @(negedge clk); n = cyc; btn_raw = 1'b0;
        wait_until(n + 60);
        n_tests++;
        if (btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL gating_no_tick_level: got %b required 0", btn_level);
        end
        m = cyc; ms_tick = 1'b1;
        exp_q.push_back(ev(K_PRESS, m + DEB));
        exp_q.push_back(ev(K_UP, m + DEB));
        wait_until(m + 60); btn_raw = 1'b1;
        exp_q.push_back(ev(K_RELEASE, m + 60 + LAT));
        exp_q.push_back(ev(K_DN, m + 60 + LAT));
        wait_until(m + 120);
        while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
            e = NONE; o = NONE;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL gating_event: got %s@%0d required %s@%0d", kname(o[31:28]), o[27:0], kname(e[31:28]), e[27:0]);
            end
        end
    endtask

    // Clean 25-tick press.
    task automatic test_basic();
        int n;
        logic [31:0] e, o;
        @(negedge clk); n = cyc; btn_raw = 1'b0;
        exp_q.push_back(ev(K_PRESS, n + LAT));
        exp_q.push_back(ev(K_UP, n + LAT));
        wait_until(n + 25); btn_raw = 1'b1;
        exp_q.push_back(ev(K_RELEASE, n + 25 + LAT));
        exp_q.push_back(ev(K_DN, n + 25 + LAT));
        wait_until(n + 45);
        n_tests++;
        if (btn_level !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_level_during_release: got %b required 1", btn_level);
        end
        wait_until(n + 100);
        while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
            e = NONE; o = NONE;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL basic_event: got %s@%0d required %s@%0d", kname(o[31:28]), o[27:0], kname(e[31:28]), e[27:0]);
            end
        end
    endtask

    // Contact bounce every 3 ticks for 30 ticks, then a stable press.
    task automatic test_bounce();
        int l;
        logic [31:0] e, o;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            btn_raw = ~btn_raw;
            wait_until(cyc + 3);
        end
        btn_raw = 1'b0; l = cyc;
        n_tests++;
        if (btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_level: got %b required 0", btn_level);
        end
        exp_q.push_back(ev(K_PRESS, l + LAT));
        exp_q.push_back(ev(K_UP, l + LAT));
        wait_until(l + 80); btn_raw = 1'b1;
        exp_q.push_back(ev(K_RELEASE, l + 80 + LAT));
        exp_q.push_back(ev(K_DN, l + 80 + LAT));
        wait_until(l + 140);
        while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
            e = NONE; o = NONE;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bounce_event: got %s@%0d required %s@%0d", kname(o[31:28]), o[27:0], kname(e[31:28]), e[27:0]);
            end
        end
    endtask

    // Auto-repeat over a 1000-tick hold.
    task automatic test_repeat();
        int n;
        logic [31:0] e, o;
        repeat_en = 1'b1;
        @(negedge clk); n = cyc; btn_raw = 1'b0;
        exp_q.push_back(ev(K_PRESS, n + LAT));
        exp_q.push_back(ev(K_UP, n + LAT));
        for (int k = 0; k < 5; k++) exp_q.push_back(ev(K_PRESS, n + LAT + DLY + k * PER));
        wait_until(n + 1000); btn_raw = 1'b1;
        exp_q.push_back(ev(K_RELEASE, n + 1000 + LAT));
        exp_q.push_back(ev(K_DN, n + 1000 + LAT));
        wait_until(n + 1060);
        repeat_en = 1'b0;
        while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
            e = NONE; o = NONE;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL repeat_event: got %s@%0d required %s@%0d", kname(o[31:28]), o[27:0], kname(e[31:28]), e[27:0]);
            end
        end
    endtask

    // No repeat; 5-tick release glitch mid-hold must be swallowed.
    task automatic test_no_repeat_glitch();
        int n;
        logic [31:0] e, o;
        repeat_en = 1'b0;
        @(negedge clk); n = cyc; btn_raw = 1'b0;
        exp_q.push_back(ev(K_PRESS, n + LAT));
        exp_q.push_back(ev(K_UP, n + LAT));
        wait_until(n + 400); btn_raw = 1'b1;
        wait_until(n + 405); btn_raw = 1'b0;
        wait_until(n + 407);
        n_tests++;
        if (btn_level !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_level: got %b required 1", btn_level);
        end
        wait_until(n + 1000); btn_raw = 1'b1;
        exp_q.push_back(ev(K_RELEASE, n + 1000 + LAT));
        exp_q.push_back(ev(K_DN, n + 1000 + LAT));
        wait_until(n + 1060);
        while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
            e = NONE; o = NONE;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL norepeat_event: got %s@%0d required %s@%0d", kname(o[31:28]), o[27:0], kname(e[31:28]), e[27:0]);
            end
        end
    endtask

    // Reset pulse in the middle of a hold, button kept down throughout.
    task automatic test_reset_mid_hold();
        int n, a, r;
        logic [31:0] e, o;
        @(negedge clk); n = cyc; btn_raw = 1'b0;
        exp_q.push_back(ev(K_PRESS, n + LAT));
        exp_q.push_back(ev(K_UP, n + LAT));
        wait_until(n + 300); a = cyc; rst_n = 1'b0;
        exp_q.push_back(ev(K_DN, a + 1));
        wait_until(a + 5);
        n_tests++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b required 000", {btn_level, press_pulse, release_pulse});
        end
        wait_until(a + 10); r = cyc; rst_n = 1'b1;
        wait_until(r + 2);
        n_tests++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_release_outputs: got %b required 000", {btn_level, press_pulse, release_pulse});
        end
        exp_q.push_back(ev(K_PRESS, r + LAT));
        exp_q.push_back(ev(K_UP, r + LAT));
        wait_until(r + 100); btn_raw = 1'b1;
        exp_q.push_back(ev(K_RELEASE, r + 100 + LAT));
        exp_q.push_back(ev(K_DN, r + 100 + LAT));
        wait_until(r + 160);
        while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
            e = NONE; o = NONE;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midreset_event: got %s@%0d required %s@%0d", kname(o[31:28]), o[27:0], kname(e[31:28]), e[27:0]);
            end
        end
    endtask

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    // 2500-tick hold gives one long_press; 1500-tick hold gives none.
    task automatic test_long_press();
        int n;
        logic [31:0] e, o;
        repeat_en = 1'b0;
        @(negedge clk); n = cyc; btn_raw = 1'b0;
        exp_q.push_back(ev(K_PRESS, n + LAT));
        exp_q.push_back(ev(K_UP, n + LAT));
        exp_q.push_back(ev(K_LONG, n + LAT + LONG));
        wait_until(n + 2500); btn_raw = 1'b1;
        exp_q.push_back(ev(K_RELEASE, n + 2500 + LAT));
        exp_q.push_back(ev(K_DN, n + 2500 + LAT));
        wait_until(n + 2560);
        @(negedge clk); n = cyc; btn_raw = 1'b0;
        exp_q.push_back(ev(K_PRESS, n + LAT));
        exp_q.push_back(ev(K_UP, n + LAT));
        wait_until(n + 1500); btn_raw = 1'b1;
        exp_q.push_back(ev(K_RELEASE, n + 1500 + LAT));
        exp_q.push_back(ev(K_DN, n + 1500 + LAT));
        wait_until(n + 1560);
        while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
            e = NONE; o = NONE;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL long_event: got %s@%0d required %s@%0d", kname(o[31:28]), o[27:0], kname(e[31:28]), e[27:0]);
            end
        end
    endtask
`endif

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tick_gating();
        test_basic();
        test_bounce();
        test_repeat();
        test_no_repeat_glitch();
        test_reset_mid_hold();
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
        test_long_press();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
